// File: rtl/opc_bus_responder.sv
// -----------------------------------------------------------------------------
// opc_bus_responder
//   Program/data RAM responder for the OPC CPU address/data/rnw bus. A
//   byte-stream loader fills the RAM while the CPU is held in reset. The CPU
//   then runs with zero-wait reads and clocked writes. On a dump request the
//   CPU is stopped again and the whole RAM is streamed out in address order.
//
// Ports
//   i_clk, i_reset          rising-edge clock, asynchronous active-high reset
//   i_address, i_rnw,       CPU bus: address, read(1)/write(0), write data
//   i_data_in
//   o_data_out, o_data_oe   CPU read data and its bus drive enable
//   o_cpu_reset_b           active-low CPU reset (0 = CPU held)
//   i_ld_valid, i_ld_data,  loader byte stream (valid/ready handshake,
//   i_ld_last, o_ld_ready   last marks the final byte)
//   i_dump_req              level request to stop the CPU and dump RAM
//   o_dump_valid, o_dump_data,
//   o_dump_addr, i_dump_ready  dump byte stream (valid/ready handshake)
//   o_dump_done             sticky flag: whole RAM has been dumped
// -----------------------------------------------------------------------------
module opc_bus_responder #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_rnw,
   input  logic [DATA_W-1:0] i_data_in,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_data_oe,
   output logic              o_cpu_reset_b,
   input  logic              i_ld_valid,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic              i_ld_last,
   output logic              o_ld_ready,
   input  logic              i_dump_req,
   output logic              o_dump_valid,
   output logic [DATA_W-1:0] o_dump_data,
   output logic [ADDR_W-1:0] o_dump_addr,
   input  logic              i_dump_ready,
   output logic              o_dump_done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DUMP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_cpu_reset_b;
   logic              r_ld_ready;
   logic              r_dump_valid;
   logic              r_dump_done;

   state_t            w_state_nxt;
   logic [ADDR_W-1:0] w_ptr_nxt;
   logic              w_cpu_reset_b_nxt;
   logic              w_ld_ready_nxt;
   logic              w_dump_valid_nxt;
   logic              w_dump_done_nxt;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_waddr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_ld_fire;
   logic              w_dump_fire;
   logic              w_run;

   // ld_ready is only ever high in LOAD, so no state qualifier is needed
   assign w_ld_fire   = i_ld_valid & r_ld_ready;
   assign w_dump_fire = r_dump_valid & i_dump_ready;
   assign w_run       = (r_state == ST_RUN);

   // Next-state, pointer and single RAM write-port selection
   always_comb begin
      w_state_nxt       = r_state;
      w_ptr_nxt         = r_ptr;
      w_cpu_reset_b_nxt = 1'b0;
      w_ld_ready_nxt    = 1'b0;
      w_dump_valid_nxt  = 1'b0;
      w_dump_done_nxt   = r_dump_done;
      w_mem_we          = 1'b0;
      w_mem_waddr       = r_ptr;
      w_mem_wdata       = i_ld_data;
      case (r_state)
         ST_LOAD: begin
            w_ld_ready_nxt = 1'b1;
            if (w_ld_fire) begin
               w_mem_we    = 1'b1;
               w_mem_waddr = r_ptr;
               w_mem_wdata = i_ld_data;
               // Stop at the last address rather than wrapping onto byte 0
               if (i_ld_last || (r_ptr == LAST_ADDR)) begin
                  w_state_nxt    = ST_RUN;
                  w_ld_ready_nxt = 1'b0;
               end else begin
                  w_ptr_nxt = r_ptr + ONE_ADDR;
               end
            end else begin
               w_ptr_nxt = r_ptr;
            end
         end
         ST_RUN: begin
            // A dump request wins over a CPU write on the same edge
            if (i_dump_req) begin
               w_state_nxt      = ST_DUMP;
               w_ptr_nxt        = {ADDR_W{1'b0}};
               w_dump_valid_nxt = 1'b1;
            end else begin
               w_cpu_reset_b_nxt = 1'b1;
               if (!i_rnw) begin
                  w_mem_we    = 1'b1;
                  w_mem_waddr = i_address;
                  w_mem_wdata = i_data_in;
               end else begin
                  w_mem_we = 1'b0;
               end
            end
         end
         ST_DUMP: begin
            w_dump_valid_nxt = 1'b1;
            if (w_dump_fire) begin
               if (r_ptr == LAST_ADDR) begin
                  w_state_nxt      = ST_DONE;
                  w_dump_valid_nxt = 1'b0;
                  w_dump_done_nxt  = 1'b1;
               end else begin
                  w_ptr_nxt = r_ptr + ONE_ADDR;
               end
            end else begin
               w_ptr_nxt = r_ptr;
            end
         end
         ST_DONE: begin
            w_dump_done_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = ST_LOAD;
         end
      endcase
   end

   // State and control registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= ST_LOAD;
         r_ptr         <= {ADDR_W{1'b0}};
         r_cpu_reset_b <= 1'b0;
         r_ld_ready    <= 1'b0;
         r_dump_valid  <= 1'b0;
         r_dump_done   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_cpu_reset_b <= w_cpu_reset_b_nxt;
         r_ld_ready    <= w_ld_ready_nxt;
         r_dump_valid  <= w_dump_valid_nxt;
         r_dump_done   <= w_dump_done_nxt;
      end
   end

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   assign o_ld_ready    = r_ld_ready;
   assign o_cpu_reset_b = r_cpu_reset_b;
   assign o_dump_valid  = r_dump_valid;
   assign o_dump_done   = r_dump_done;
   // Dump outputs follow the pointer, which only moves on a handshake
   assign o_dump_addr   = r_dump_valid ? r_ptr : {ADDR_W{1'b0}};
   assign o_dump_data   = r_dump_valid ? r_mem[r_ptr] : {DATA_W{1'b0}};
   // Zero-wait CPU read path
   assign o_data_out    = w_run ? r_mem[i_address] : {DATA_W{1'b0}};
   assign o_data_oe     = w_run & i_rnw;

endmodule

// File: tb/tb_opc_bus_responder.sv
module tb_opc_bus_responder;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [10:0] i_address = 11'd0;
   logic        i_rnw = 1'b1;
   logic [7:0]  i_data_in = 8'd0;
   logic [7:0]  o_data_out;
   logic        o_data_oe;
   logic        o_cpu_reset_b;
   logic        i_ld_valid = 1'b0;
   logic [7:0]  i_ld_data = 8'd0;
   logic        i_ld_last = 1'b0;
   logic        o_ld_ready;
   logic        i_dump_req = 1'b0;
   logic        o_dump_valid;
   logic [7:0]  o_dump_data;
   logic [10:0] o_dump_addr;
   logic        i_dump_ready = 1'b0;
   logic        o_dump_done;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_mem [0:2047];

   opc_bus_responder #(.ADDR_W(11), .DATA_W(8)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_address(i_address), .i_rnw(i_rnw),
      .i_data_in(i_data_in), .o_data_out(o_data_out), .o_data_oe(o_data_oe),
      .o_cpu_reset_b(o_cpu_reset_b), .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
      .i_ld_last(i_ld_last), .o_ld_ready(o_ld_ready), .i_dump_req(i_dump_req),
      .o_dump_valid(o_dump_valid), .o_dump_data(o_dump_data), .o_dump_addr(o_dump_addr),
      .i_dump_ready(i_dump_ready), .o_dump_done(o_dump_done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int i);
      logic [31:0] t;
      t = i * 7 + 3;
      return t[7:0];
   endfunction

   // called at a negedge; presents one byte across one posedge, ends at negedge
   task automatic load_byte(input logic [7:0] d, input logic last);
      i_ld_valid = 1'b1;
      i_ld_data  = d;
      i_ld_last  = last;
      @(negedge clk);
   endtask

   task automatic assert_reset();
      @(negedge clk);
      i_reset = 1'b1;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      i_reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      checks++; if (o_ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got %0b exp 0", o_ld_ready); end
      checks++; if (o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL rst_cpu_reset_b got %0b exp 0", o_cpu_reset_b); end
      checks++; if (o_data_oe !== 1'b0) begin errors++; $display("FAIL rst_data_oe got %0b exp 0", o_data_oe); end
      checks++; if (o_dump_valid !== 1'b0) begin errors++; $display("FAIL rst_dump_valid got %0b exp 0", o_dump_valid); end
      checks++; if (o_dump_done !== 1'b0) begin errors++; $display("FAIL rst_dump_done got %0b exp 0", o_dump_done); end
      checks++; if (o_dump_addr !== 11'd0) begin errors++; $display("FAIL rst_dump_addr got %h exp 000", o_dump_addr); end
      release_reset();
      checks++; if (o_ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready_rise got %0b exp 1", o_ld_ready); end
   endtask

   task automatic test_full_load();
      for (int i = 0; i < 2048; i++) begin
         load_byte(pat(i), 1'b0);
         exp_mem[i] = pat(i);
      end
      checks++; if (o_ld_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready_drop got %0b exp 0", o_ld_ready); end
      checks++; if (o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL full_cpu_early got %0b exp 0", o_cpu_reset_b); end
      load_byte(8'hEE, 1'b0);
      load_byte(8'hEF, 1'b1);
      i_ld_valid = 1'b0;
      i_ld_last  = 1'b0;
      checks++; if (o_cpu_reset_b !== 1'b1) begin errors++; $display("FAIL full_cpu_rise got %0b exp 1", o_cpu_reset_b); end
      checks++; if (o_ld_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready_low got %0b exp 0", o_ld_ready); end
      i_address = 11'h000; #1;
      checks++; if (o_data_out !== exp_mem[0]) begin errors++; $display("FAIL full_ram0 got %h exp %h", o_data_out, exp_mem[0]); end
      i_address = 11'h7FF; #1;
      checks++; if (o_data_out !== exp_mem[2047]) begin errors++; $display("FAIL full_ram7ff got %h exp %h", o_data_out, exp_mem[2047]); end
   endtask

   task automatic test_load_basic();
      logic [7:0] v [0:3];
      v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44;
      assert_reset();
      release_reset();
      checks++; if (o_ld_ready !== 1'b1) begin errors++; $display("FAIL basic_ld_ready got %0b exp 1", o_ld_ready); end
      checks++; if (o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL basic_cpu_held got %0b exp 0", o_cpu_reset_b); end
      for (int i = 0; i < 4; i++) begin
         load_byte(v[i], (i == 3) ? 1'b1 : 1'b0);
         exp_mem[i] = v[i];
      end
      i_ld_valid = 1'b0;
      i_ld_last  = 1'b0;
      checks++; if (o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL basic_cpu_at_hs got %0b exp 0", o_cpu_reset_b); end
      checks++; if (o_ld_ready !== 1'b0) begin errors++; $display("FAIL basic_ld_ready_drop got %0b exp 0", o_ld_ready); end
      @(negedge clk);
      checks++; if (o_cpu_reset_b !== 1'b1) begin errors++; $display("FAIL basic_cpu_rise got %0b exp 1", o_cpu_reset_b); end
      checks++; if (o_ld_ready !== 1'b0) begin errors++; $display("FAIL basic_ld_ready_low got %0b exp 0", o_ld_ready); end
      for (int i = 0; i < 5; i++) begin
         i_address = 11'(i); #1;
         checks++; if (o_data_out !== exp_mem[i]) begin errors++; $display("FAIL basic_ram%0d got %h exp %h", i, o_data_out, exp_mem[i]); end
      end
   endtask

   task automatic test_run_rw();
      @(negedge clk);
      i_address = 11'h7FF; i_data_in = 8'hA5; i_rnw = 1'b0; #1;
      checks++; if (o_data_oe !== 1'b0) begin errors++; $display("FAIL rw_oe_write got %0b exp 0", o_data_oe); end
      exp_mem[2047] = 8'hA5;
      @(negedge clk);
      i_rnw = 1'b1; i_data_in = 8'h00; #1;
      checks++; if (o_data_out !== 8'hA5) begin errors++; $display("FAIL rw_readback got %h exp a5", o_data_out); end
      checks++; if (o_data_oe !== 1'b1) begin errors++; $display("FAIL rw_oe_read got %0b exp 1", o_data_oe); end
   endtask

   task automatic test_dump();
      int k;
      @(negedge clk);
      i_dump_req = 1'b1;
      @(negedge clk);
      checks++; if (o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL dump_cpu_stop got %0b exp 0", o_cpu_reset_b); end
      k = 0;
      for (int c = 0; c < 5000 && k < 2048; c++) begin
         checks++;
         if (o_dump_valid !== 1'b1 || o_dump_addr !== 11'(k) || o_dump_data !== exp_mem[k]) begin
            errors++;
            $display("FAIL dump_byte got v=%0b a=%h d=%h exp v=1 a=%h d=%h", o_dump_valid, o_dump_addr, o_dump_data, 11'(k), exp_mem[k]);
         end
         i_dump_ready = (c % 2 == 1);
         @(negedge clk);
         if (i_dump_ready) k++;
      end
      i_dump_ready = 1'b0;
      checks++; if (k != 2048) begin errors++; $display("FAIL dump_timeout got %0d exp 2048", k); end
      checks++; if (o_dump_done !== 1'b1) begin errors++; $display("FAIL dump_done got %0b exp 1", o_dump_done); end
      checks++; if (o_dump_valid !== 1'b0) begin errors++; $display("FAIL dump_valid_end got %0b exp 0", o_dump_valid); end
      i_dump_req = 1'b0;
      @(negedge clk);
      checks++; if (o_dump_done !== 1'b1 || o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL done_static got done=%0b cpu=%0b exp 1 0", o_dump_done, o_cpu_reset_b); end
   endtask

   task automatic test_dump_in_load();
      i_dump_req = 1'b1;
      assert_reset();
      checks++; if (o_dump_done !== 1'b0) begin errors++; $display("FAIL dil_done_clear got %0b exp 0", o_dump_done); end
      release_reset();
      load_byte(8'h77, 1'b0);
      exp_mem[0] = 8'h77;
      checks++; if (o_dump_valid !== 1'b0 || o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL dil_in_load got v=%0b cpu=%0b exp 0 0", o_dump_valid, o_cpu_reset_b); end
      load_byte(8'h88, 1'b1);
      exp_mem[1] = 8'h88;
      i_ld_valid = 1'b0;
      i_ld_last  = 1'b0;
      checks++; if (o_dump_valid !== 1'b0 || o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL dil_run_entry got v=%0b cpu=%0b exp 0 0", o_dump_valid, o_cpu_reset_b); end
      @(negedge clk);
      checks++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 11'd0 || o_dump_data !== 8'h77) begin
         errors++; $display("FAIL dil_dump_start got v=%0b a=%h d=%h exp 1 000 77", o_dump_valid, o_dump_addr, o_dump_data);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (o_cpu_reset_b !== 1'b0 || o_dump_addr !== 11'd0) begin errors++; $display("FAIL dil_hold got cpu=%0b a=%h exp 0 000", o_cpu_reset_b, o_dump_addr); end
      end
      i_dump_req = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      assert_reset();
      release_reset();
      for (int i = 0; i < 3; i++) begin
         load_byte(8'h50 + 8'(i), 1'b0);
         exp_mem[i] = 8'h50 + 8'(i);
      end
      checks++; if (o_ld_ready !== 1'b1) begin errors++; $display("FAIL mid_ld_ready_pre got %0b exp 1", o_ld_ready); end
      i_ld_valid = 1'b0;
      i_reset = 1'b1; #1;
      checks++; if (o_ld_ready !== 1'b0) begin errors++; $display("FAIL mid_ld_ready_abort got %0b exp 0", o_ld_ready); end
      checks++; if (o_cpu_reset_b !== 1'b0) begin errors++; $display("FAIL mid_cpu_abort got %0b exp 0", o_cpu_reset_b); end
      release_reset();
      load_byte(8'hA0, 1'b0);
      load_byte(8'hB0, 1'b1);
      exp_mem[0] = 8'hA0;
      exp_mem[1] = 8'hB0;
      i_ld_valid = 1'b0;
      i_ld_last  = 1'b0;
      @(negedge clk);
      checks++; if (o_cpu_reset_b !== 1'b1) begin errors++; $display("FAIL mid_cpu_rise got %0b exp 1", o_cpu_reset_b); end
      for (int i = 0; i < 4; i++) begin
         i_address = 11'(i); #1;
         checks++; if (o_data_out !== exp_mem[i]) begin errors++; $display("FAIL mid_ram%0d got %h exp %h", i, o_data_out, exp_mem[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_load_basic();
      test_run_rw();
      test_dump();
      test_dump_in_load();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end

endmodule
